// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock through a
// single W+1-bit add/subtract unit, 2W-bit product after W steps.

module booth_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W:0]   z
);
  // Operands are sign-extended first so A-M with M = -2^(W-1) cannot overflow.
  assign z = sub ? ({x[W-1], x} - {y[W-1], y}) : ({x[W-1], x} + {y[W-1], y});
endmodule

module booth_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, q, m;
  logic          q_1;
  logic [CW-1:0] cnt;
  logic [W-1:0]  y;
  logic          flag;
  logic [W:0]    sum;
  logic          last;

  assign last = (cnt == CW'(W - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise unlisted paths keep their old value and a latch is inferred.
  always_comb begin
    y    = '0;
    flag = 1'b0;
    case ({q[0], q_1})
      2'b01:   y = m;
      2'b10: begin
        y    = m;
        flag = 1'b1;
      end
      default: ;
    endcase
  end

  booth_addsub #(.W(W)) u_addsub (
    .x   (acc),
    .y   (y),
    .sub (flag),
    .z   (sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: all datapath registers, product included, are cleared by reset so an
  // aborted operation can never leave a stale result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          q   <= b;
          m   <= a;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        RUN: begin
          // Arithmetic shift right of {sum, Q, q_1} by one position.
          acc <= sum[W:1];
          q   <= {sum[0], q[W-1:1]};
          q_1 <= q[0];
          cnt <= cnt + CW'(1);
          if (last) product <= {sum[W:1], sum[0], q[W-1:1]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: W=8 vector table and corner sequences,
// plus an exhaustive W=4 sweep against a signed reference product.

module tb_booth_mul_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    bit          toggle;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  booth_mul_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  booth_mul_seq #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(p4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input bit toggle);
    int n, nbusy;
    logic [15:0] want;
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back(exp);
    n = 0; nbusy = 0;
    do begin
      tick();
      n++;
      if (busy8) nbusy++;
      if (toggle) begin
        a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'($urandom_range(0, 1));
      end else begin
        start8 = 1'b0;
      end
    end while (!done8 && n < 40);
    start8 = 1'b0;
    check($sformatf("done_latency8 a=%0h b=%0h", a, b), 64'(n - 1), 64'd8);
    check($sformatf("busy_cycles8 a=%0h b=%0h", a, b), 64'(nbusy), 64'd9);
    want = q8.pop_front();
    check($sformatf("product8 a=%0h b=%0h", a, b), 64'(p8), 64'(want));
    tick();
    check("idle_after_done8", 64'({busy8, done8}), 64'd0);
    check("product8_held", 64'(p8), 64'(want));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int n;
    logic [7:0] want;
    a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(exp);
    n = 0;
    do begin
      tick();
      n++;
      start4 = 1'b0;
      a4 = ~a4;
      b4 = ~b4;
    end while (!done4 && n < 20);
    check($sformatf("done_latency4 a=%0h b=%0h", a, b), 64'(n - 1), 64'd4);
    want = q4.pop_front();
    check($sformatf("product4 a=%0h b=%0h", a, b), 64'(p4), 64'(want));
    tick();
    tick();
    check($sformatf("product4_held a=%0h b=%0h", a, b), 64'(p4), 64'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, n;
    logic [15:0] want;
    logic [7:0]  t5_a[3], t5_b[3];
    logic [15:0] t5_p[3];

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_product8", 64'(p8), 64'd0);
    check("reset_product4", 64'(p4), 64'd0);

    // T1..T3 plus extra sign patterns; hand-computed products.
    vecs[0] = '{8'h03, 8'hFB, 16'hFFF1, 1'b0};
    vecs[1] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    vecs[2] = '{8'h80, 8'h7F, 16'hC080, 1'b0};
    vecs[3] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};
    vecs[4] = '{8'h01, 8'h80, 16'hFF80, 1'b0};
    vecs[5] = '{8'hFD, 8'h55, 16'hFF01, 1'b0};
    vecs[6] = '{8'h07, 8'h06, 16'h002A, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 16'h0000, 1'b1};
    vecs[8] = '{8'hFF, 8'hFF, 16'h0001, 1'b1};
    for (int i = 0; i < 9; i++) run8(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].toggle);

    nd = 0;
    repeat (12) begin
      tick();
      if (done8) nd++;
    end
    check("no_extra_done", 64'(nd), 64'd0);

    // T4: reset four steps into RUN aborts the operation.
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    q8.push_back(16'h0001);
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q8.delete();
    check("abort_busy8", 64'(busy8), 64'd0);
    check("abort_done8", 64'(done8), 64'd0);
    check("abort_product8", 64'(p8), 64'd0);
    nd = 0;
    repeat (10) begin
      tick();
      if (done8) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);
    run8(8'h07, 8'h06, 16'h002A, 1'b0);

    // T5: start held high, three back-to-back operations.
    t5_a = '{8'h03, 8'h80, 8'h07};
    t5_b = '{8'hFB, 8'h80, 8'h06};
    t5_p = '{16'hFFF1, 16'h4000, 16'h002A};
    a8 = t5_a[0]; b8 = t5_b[0]; start8 = 1'b1;
    q8.push_back(t5_p[0]);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done8 && n < 40);
      check($sformatf("b2b_spacing op%0d", k), 64'(n), (k == 0) ? 64'd9 : 64'd10);
      want = q8.pop_front();
      check($sformatf("b2b_product op%0d", k), 64'(p8), 64'(want));
      if (k < 2) begin
        a8 = t5_a[k+1]; b8 = t5_b[k+1];
        q8.push_back(t5_p[k+1]);
      end else begin
        start8 = 1'b0;
      end
    end
    tick();
    tick();
    check("b2b_idle", 64'(busy8), 64'd0);

    // T6: exhaustive W=4 against a signed reference.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic signed [3:0] sa, sb;
        int pr;
        sa = 4'(i);
        sb = 4'(j);
        pr = sa * sb;
        run4(4'(i), 4'(j), pr[7:0]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
